player_update_ctrl: RTL and testbench

Frame-synchronous sequencer for player state in the game display path. It samples the movement keys once per frame at the start of vertical sync and computes a clamped player position. It then hands the new position to the renderer with a start/done handshake. Position outputs change only during the update step, so the scanout logic always draws a stable position for a whole frame.

---
 rtl/game_pkg.sv | 19 +
 rtl/sync_fall_det.sv | 50 +++++
 rtl/player_update_ctrl.sv | 151 +++++++++++++++
 tb/tb_player_update_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-display definitions: screen defaults, key bit positions, and
// the player update sequencer state encoding.
package game_pkg;

   localparam int H_RES_DEFAULT = 640;
   localparam int V_RES_DEFAULT = 480;

   localparam int KEY_RIGHT = 0;
   localparam int KEY_DOWN  = 1;
   localparam int KEY_LEFT  = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_UPDATE = 2'd2,
      ST_RENDER = 2'd3
   } state_e;

endpackage

// File: rtl/sync_fall_det.sv
// Optional 2-FF synchronizer followed by an optional falling-edge detector.
// SYNC_EN=1 inserts the two synchronizer flops; EDGE_EN=1 makes q_o a
// one-cycle pulse on every 1->0 transition of the (synchronized) input,
// otherwise q_o is the synchronized level itself.
module sync_fall_det #(
   parameter int W       = 1,
   parameter bit SYNC_EN = 1'b1,
   parameter bit EDGE_EN = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sync_w;

   generate
      if (SYNC_EN) begin : g_sync
         logic [W-1:0] s1_q, s2_q;
         // two-stage metastability filter, cleared on reset
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               s1_q <= '0;
               s2_q <= '0;
            end else begin
               s1_q <= d_i;
               s2_q <= s1_q;
            end
         end
         assign sync_w = s2_q;
      end else begin : g_nosync
         assign sync_w = d_i;
      end

      if (EDGE_EN) begin : g_edge
         logic [W-1:0] prev_q;
         // previous-cycle copy; reset to 0 so a low input at reset release
         // never produces a spurious edge
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) prev_q <= '0;
            else      prev_q <= sync_w;
         end
         assign q_o = prev_q & ~sync_w;
      end else begin : g_level
         assign q_o = sync_w;
      end
   endgenerate

endmodule

// File: rtl/player_update_ctrl.sv
// Frame-synchronous player position sequencer. Samples the movement keys on
// each vsync falling edge, steps and bounds the position, then hands off to
// the renderer with a start pulse and waits for done (or a timeout).
// Frame edges arriving while busy are dropped.
// Build option: define PLAYER_WRAP_EN to wrap the position at the screen
// limits instead of saturating.
module player_update_ctrl
   import game_pkg::*;
#(
   parameter int H_RES          = H_RES_DEFAULT,
   parameter int V_RES          = V_RES_DEFAULT,
   parameter int SPRITE         = 2,
   parameter int STEP           = 1,
   parameter int RENDER_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic [2:0]  keys,
   input  logic        render_done,
   output logic [9:0]  pos_x,
   output logic [9:0]  pos_y,
   output logic        render_start,
   output logic        busy,
   output logic [15:0] frame_count
);

   localparam int TO_W = $clog2(RENDER_TIMEOUT + 1);
   localparam logic signed [10:0] STEP_S = 11'(STEP);
   localparam logic signed [10:0] X_LIM  = 11'(H_RES - SPRITE);
   localparam logic signed [10:0] Y_LIM  = 11'(V_RES - SPRITE);
   localparam logic [9:0] X_RST = 10'(H_RES / 2);
   localparam logic [9:0] Y_RST = 10'(V_RES / 2);

   logic [2:0] keys_s;
   logic       frame_edge;

   sync_fall_det #(.W(3), .SYNC_EN(1'b1), .EDGE_EN(1'b0)) u_key_sync (
      .clk (clk),
      .rst (rst),
      .d_i (keys),
      .q_o (keys_s)
   );

   // vsync is already in the clk domain: only the edge detector is needed
   sync_fall_det #(.W(1), .SYNC_EN(1'b0), .EDGE_EN(1'b1)) u_vs_edge (
      .clk (clk),
      .rst (rst),
      .d_i (vsync),
      .q_o (frame_edge)
   );

   state_e            state_q, state_d;
   logic [2:0]        key_lat_q, key_lat_d;
   logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [15:0]       fc_q, fc_d;
   logic              rs_q, rs_d;
   logic [TO_W-1:0]   to_q, to_d;

   logic signed [10:0] dx, dy, nx, ny;
   logic [9:0]         x_fit, y_fit;

   // step and bound the next position from the latched keys
   always_comb begin
      dx = '0;
      case ({key_lat_q[KEY_LEFT], key_lat_q[KEY_RIGHT]})
         2'b01:   dx = STEP_S;
         2'b10:   dx = -STEP_S;
         default: dx = '0;
      endcase
      dy = key_lat_q[KEY_DOWN] ? STEP_S : '0;
      nx = $signed({1'b0, pos_x_q}) + dx;
      ny = $signed({1'b0, pos_y_q}) + dy;
`ifdef PLAYER_WRAP_EN
      if (nx < 0)          x_fit = X_LIM[9:0];
      else if (nx > X_LIM) x_fit = '0;
      else                 x_fit = nx[9:0];
      if (ny < 0)          y_fit = Y_LIM[9:0];
      else if (ny > Y_LIM) y_fit = '0;
      else                 y_fit = ny[9:0];
`else
      if (nx < 0)          x_fit = '0;
      else if (nx > X_LIM) x_fit = X_LIM[9:0];
      else                 x_fit = nx[9:0];
      if (ny < 0)          y_fit = '0;
      else if (ny > Y_LIM) y_fit = Y_LIM[9:0];
      else                 y_fit = ny[9:0];
`endif
   end

   // sequencer next state and register updates
   always_comb begin
      state_d   = state_q;
      key_lat_d = key_lat_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      fc_d      = fc_q;
      rs_d      = 1'b0;
      to_d      = to_q;
      case (state_q)
         ST_IDLE: begin
            if (frame_edge) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            key_lat_d = keys_s;
            state_d   = ST_UPDATE;
         end
         ST_UPDATE: begin
            pos_x_d = x_fit;
            pos_y_d = y_fit;
            fc_d    = fc_q + 16'd1;
            rs_d    = 1'b1;
            to_d    = '0;
            state_d = ST_RENDER;
         end
         ST_RENDER: begin
            if (render_done || to_q == TO_W'(RENDER_TIMEOUT)) state_d = ST_IDLE;
            else                                              to_d    = to_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         key_lat_q <= '0;
         pos_x_q   <= X_RST;
         pos_y_q   <= Y_RST;
         fc_q      <= '0;
         rs_q      <= 1'b0;
         to_q      <= '0;
      end else begin
         state_q   <= state_d;
         key_lat_q <= key_lat_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         fc_q      <= fc_d;
         rs_q      <= rs_d;
         to_q      <= to_d;
      end
   end

   assign pos_x        = pos_x_q;
   assign pos_y        = pos_y_q;
   assign frame_count  = fc_q;
   assign render_start = rs_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_player_update_ctrl.sv
// Directed bench for player_update_ctrl (default parameters).
module tb_player_update_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        vsync = 1'b1;
   logic [2:0]  keys = 3'b000;
   logic        render_done = 1'b0;
   logic [9:0]  pos_x, pos_y;
   logic        render_start, busy;
   logic [15:0] frame_count;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_l[3];

   player_update_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .vsync        (vsync),
      .keys         (keys),
      .render_done  (render_done),
      .pos_x        (pos_x),
      .pos_y        (pos_y),
      .render_start (render_start),
      .busy         (busy),
      .frame_count  (frame_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      rst = 1'b0; vsync = 1'b1; keys = 3'b000; render_done = 1'b0;
      repeat (2) tick;
      rst = 1'b1;
      tick;
   endtask

   // leaves the bench inside cycle E (vsync just driven low)
   task automatic edge_fall(input logic [2:0] k);
      keys = k; vsync = 1'b1;
      repeat (4) tick;
      vsync = 1'b0;
   endtask

   // from within RENDER: wait dly cycles, pulse done, wait for idle
   task automatic finish_frame(input int dly);
      repeat (dly) tick;
      render_done = 1'b1;
      tick;
      render_done = 1'b0;
      for (int i = 0; i < 2000 && busy; i++) tick;
      chk("busy_release", {31'd0, busy}, 32'd0);
      vsync = 1'b1;
   endtask

   task automatic do_frame(input logic [2:0] k, input int dly);
      edge_fall(k);
      repeat (3) tick;
      finish_frame(dly);
   endtask

   initial begin
`ifdef PLAYER_WRAP_EN
      exp_l[0] = 0; exp_l[1] = 638; exp_l[2] = 637;
`else
      exp_l[0] = 0; exp_l[1] = 0;   exp_l[2] = 0;
`endif

      // reset values
      do_reset;
      chk("rst_x",  pos_x, 320);
      chk("rst_y",  pos_y, 240);
      chk("rst_rs", render_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fc", frame_count, 0);

      // first frame, no keys, done after 10 cycles
      edge_fall(3'b000);
      tick; chk("e1_busy", busy, 1); chk("e1_rs", render_start, 0);
      tick; chk("e2_rs", render_start, 0); chk("e2_fc", frame_count, 0);
      tick; chk("e3_rs", render_start, 1);
      chk("e3_x", pos_x, 320); chk("e3_y", pos_y, 240); chk("e3_fc", frame_count, 1);
      tick; chk("e4_rs", render_start, 0); chk("e4_busy", busy, 1);
      finish_frame(9);
      chk("f1_fc", frame_count, 1);

      // right held for 5 frames
      do_reset;
      for (int i = 0; i < 5; i++) do_frame(3'b001, 2);
      chk("right_x", pos_x, 325); chk("right_y", pos_y, 240); chk("right_fc", frame_count, 5);

      // left+right cancel, down moves
      do_reset;
      for (int i = 0; i < 3; i++) do_frame(3'b111, 0);
      chk("lrd_x", pos_x, 320); chk("lrd_y", pos_y, 243); chk("lrd_fc", frame_count, 3);

      // walk to x=1, then left across the boundary
      do_reset;
      for (int i = 0; i < 319; i++) do_frame(3'b100, 0);
      chk("walk_x", pos_x, 1);
      for (int i = 0; i < 3; i++) begin
         do_frame(3'b100, 0);
         chk("edge_x", pos_x, exp_l[i]);
      end
      chk("edge_y", pos_y, 240);

      // done ignored before RENDER, dropped frame, then timeout
      do_reset;
      edge_fall(3'b000);
      render_done = 1'b1;
      tick; tick;           // E+2
      render_done = 1'b0;
      tick;                 // E+3
      chk("ov_rs", render_start, 1); chk("ov_fc", frame_count, 1);
      vsync = 1'b1; tick; tick;  // E+5
      vsync = 1'b0;              // edge while in RENDER
      tick; chk("ov_fc_drop", frame_count, 1);
      tick; tick; chk("ov_rs_drop", render_start, 0);  // E+8
      repeat (1026 - 8) tick;
      chk("to_busy_hold", busy, 1);
      tick;
      chk("to_busy_drop", busy, 0);
      chk("to_fc", frame_count, 1);
      do_frame(3'b000, 0);
      chk("to_next_fc", frame_count, 2);

      // reset asserted during UPDATE
      do_reset;
      do_frame(3'b001, 0);
      chk("pre_x", pos_x, 321); chk("pre_fc", frame_count, 1);
      edge_fall(3'b001);
      tick; tick;           // UPDATE
      rst = 1'b0;
      #1;
      chk("ar_x", pos_x, 320); chk("ar_y", pos_y, 240); chk("ar_fc", frame_count, 0);
      chk("ar_rs", render_start, 0); chk("ar_busy", busy, 0);
      vsync = 1'b1; keys = 3'b000;
      tick; tick;
      rst = 1'b1;
      tick;
      edge_fall(3'b000);
      repeat (3) tick;
      chk("post_rs", render_start, 1); chk("post_fc", frame_count, 1); chk("post_x", pos_x, 320);
      finish_frame(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
